// File: rtl/fnd_scan_controller_pkg.sv
// Shared constants, FSM encoding and double-dabble helpers for the FND scan path.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package fnd_scan_controller_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 4;
  localparam int BIN_W      = 14;
  localparam int MAX_VALUE  = 9999;
  localparam int BCD_REG_W  = NUM_DIGITS * BCD_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // All digit selects inactive (common-anode, active-low).
  localparam logic [NUM_DIGITS-1:0] DIGIT_OFF = 4'b1111;

  // Segment pattern the downstream font decoder emits when blanked.
  localparam logic [7:0] FONT_BLANK = 8'hff;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
  function automatic logic [BCD_REG_W-1:0] dd_adjust(input logic [BCD_REG_W-1:0] bcd);
    logic [BCD_REG_W-1:0] r;
    r = bcd;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r[k*BCD_W +: BCD_W] >= BCD_W'(5)) begin
        r[k*BCD_W +: BCD_W] = r[k*BCD_W +: BCD_W] + BCD_W'(3);
      end
    end
    return r;
  endfunction

  // Clamp anything above four decimal digits to 9999.
  function automatic logic [BIN_W-1:0] saturate(input logic [BIN_W-1:0] v);
    return (v > BIN_W'(MAX_VALUE)) ? BIN_W'(MAX_VALUE) : v;
  endfunction

endpackage

// File: rtl/fnd_scan_controller_if.sv
// Load/status/display bundle between the value source, the scan controller and the font decoder.
// Latency: n/a (wires only).
// Backpressure: none; i_load is a strobe honoured only while o_busy is low.
import fnd_scan_controller_pkg::*;

interface fnd_scan_controller_if;
  logic [BIN_W-1:0]      i_value;
  logic                  i_load;
  logic                  o_busy;
  logic [BCD_W-1:0]      o_bcd;
  logic                  o_blank;
  logic [NUM_DIGITS-1:0] o_digit;

  modport slave (
    input  i_value, i_load,
    output o_busy, o_bcd, o_blank, o_digit
  );

  modport master (
    output i_value, i_load,
    input  o_busy, o_bcd, o_blank, o_digit
  );
endinterface

// File: rtl/fnd_scan_controller_bin_to_bcd_seq.sv
// Sequential double-dabble: captures a saturated binary value, then one add-3/shift per step.
// Latency: 14 steps after capture; o_done flags the step that completes the result.
// Backpressure: none; the caller sequences i_start/i_step.
import fnd_scan_controller_pkg::*;

module fnd_scan_controller_bin_to_bcd_seq (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_step,
  input  logic [BIN_W-1:0]     i_value,
  output logic [BCD_REG_W-1:0] o_bcd,
  output logic                 o_done
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0]     bin_q, bin_d;
  logic [BCD_REG_W-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // Capture on start, otherwise adjust-and-shift one binary bit into the BCD register per step.
  always_comb begin
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (i_start) begin
      bin_d = saturate(i_value);
      bcd_d = '0;
      cnt_d = '0;
    end else if (i_step) begin
      {bcd_d, bin_d} = {dd_adjust(bcd_q), bin_q} << 1;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Conversion state registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_bcd  = bcd_q;
  assign o_done = i_step && (cnt_q == CNT_W'(BIN_W - 1));

endmodule

// File: rtl/fnd_scan_controller.sv
// Binary-to-BCD load path plus 4-digit time-multiplexed scan into one font decoder.
// Latency: o_busy high 15 cycles after the load edge; display updates on the edge o_busy drops.
// Backpressure: i_load is ignored while o_busy is high; nothing is queued.
import fnd_scan_controller_pkg::*;

module fnd_scan_controller #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1_000,
  parameter int LZ_BLANK = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  fnd_scan_controller_if.slave bus
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int PRE_W = $clog2(DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  state_e               state_q, state_d;
  logic                 conv_start, conv_step, conv_done, commit;
  logic [BCD_REG_W-1:0] conv_bcd;
  logic [BCD_REG_W-1:0] disp_q, disp_d;
  logic [PRE_W-1:0]     presc_q, presc_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  fnd_scan_controller_bin_to_bcd_seq u_conv (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (conv_start),
    .i_step  (conv_step),
    .i_value (bus.i_value),
    .o_bcd   (conv_bcd),
    .o_done  (conv_done)
  );

  // Load handshake FSM: IDLE accepts a load, CONV steps the converter, COMMIT publishes.
  always_comb begin
    state_d    = state_q;
    conv_start = 1'b0;
    conv_step  = 1'b0;
    commit     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_load) begin
          conv_start = 1'b1;
          state_d    = ST_CONV;
        end
      end
      ST_CONV: begin
        conv_step = 1'b1;
        if (conv_done) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Display latch and free-running scan prescaler/index, independent of conversion.
  always_comb begin
    disp_d  = commit ? conv_bcd : disp_q;
    presc_d = presc_q + PRE_W'(1);
    idx_d   = idx_q;
    if (presc_q == PRE_W'(DIV - 1)) begin
      presc_d = '0;
      idx_d   = idx_q + IDX_W'(1);
    end
  end

  // Controller state registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      disp_q  <= '0;
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.o_busy  = (state_q != ST_IDLE);
  assign bus.o_bcd   = disp_q[idx_q*BCD_W +: BCD_W];
  assign bus.o_digit = DIGIT_OFF ^ (NUM_DIGITS'(1) << idx_q);

  // Blank a non-ones digit when it and every digit above it are zero.
  always_comb begin
    bus.o_blank = 1'b0;
    if ((LZ_BLANK != 0) && (idx_q != '0)) begin
      bus.o_blank = ((disp_q >> (idx_q * BCD_W)) == '0);
    end
  end

endmodule
